// File: rtl/stair_scheduler.sv
// stair_scheduler: shares one VGA plot port between NUM_STAIRS scrolling stair rectangles.
// Define STAIR_SCHED_PALETTE_EN to draw each stair in its own colour (stair k uses 1 + k mod 7);
// without it every stair draws 3'b100. Erase always writes 3'b000.
module stair_scheduler #(
    parameter int NUM_STAIRS   = 3,
    parameter int STAIR_W      = 40,
    parameter int STAIR_H      = 5,
    parameter int X_BASE       = 10,
    parameter int X_PITCH      = 50,
    parameter int Y_BASE       = 40,
    parameter int Y_PITCH      = 35,
    parameter int Y_WRAP       = 114,
    parameter int FRAME_CYCLES = 833_334
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       go,
    input  logic       pause,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic [7:0] frame_count,
    output logic [2:0] current_state
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_WAIT = 3'd1,
        DRAW       = 3'd2,
        WAIT       = 3'd3,
        ERASE      = 3'd4,
        UPDATE     = 3'd5
    } state_t;

    state_t      state;
    logic [15:0] cx;
    logic [15:0] ry;
    logic [2:0]  s;
    logic [31:0] timer;
    // Eight slots so any 3-bit stair index is in range; only the first NUM_STAIRS are ever scanned.
    logic [6:0]  y_pos [8];
    logic        last_cx;
    logic        last_ry;
    logic        last_s;
    logic        scanning;
    logic [2:0]  draw_colour;

    assign last_cx       = cx == 16'(STAIR_W - 1);
    assign last_ry       = ry == 16'(STAIR_H - 1);
    assign last_s        = s == 3'(NUM_STAIRS - 1);
    assign scanning      = state == DRAW || state == ERASE;
    assign busy          = state == DRAW || state == ERASE || state == UPDATE;
    assign current_state = state;

`ifdef STAIR_SCHED_PALETTE_EN
    assign draw_colour = 3'(1 + int'(s) % 7);
`else
    assign draw_colour = 3'b100;
`endif

    // Sequencer: state, scan counters, frame timer, stair positions and registered pixel outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cx          <= '0;
            ry          <= '0;
            s           <= '0;
            timer       <= '0;
            x           <= '0;
            y           <= '0;
            colour      <= '0;
            plot        <= 1'b0;
            frame_count <= '0;
            for (int k = 0; k < 8; k++) y_pos[k] <= 7'(Y_BASE + k * Y_PITCH);
        end else begin
            plot <= scanning;
            if (scanning) begin
                x      <= 8'(X_BASE + int'(s) * X_PITCH + int'(cx));
                y      <= 7'(int'(y_pos[s]) + int'(ry));
                colour <= state == DRAW ? draw_colour : 3'b000;
            end
            case (state)
                IDLE:       if (go) state <= START_WAIT;
                START_WAIT: if (!go) state <= DRAW;
                DRAW, ERASE: begin
                    // Counters wrap back to zero on the last pixel, so every phase starts from a clean scan.
                    cx <= last_cx ? '0 : cx + 16'd1;
                    if (last_cx) ry <= last_ry ? '0 : ry + 16'd1;
                    if (last_cx && last_ry) s <= last_s ? '0 : s + 3'd1;
                    if (last_cx && last_ry && last_s) begin
                        state <= state == DRAW ? WAIT : UPDATE;
                        timer <= 32'(FRAME_CYCLES - 1);
                    end
                end
                WAIT: begin
                    if (timer == 0 && !pause) state <= ERASE;
                    else if (timer != 0) timer <= timer - 32'd1;
                end
                UPDATE: begin
                    for (int k = 0; k < 8; k++) y_pos[k] <= y_pos[k] == 7'd0 ? 7'(Y_WRAP) : y_pos[k] - 7'd1;
                    frame_count <= frame_count + 8'd1;
                    state       <= DRAW;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stair_scheduler.sv
// tb_stair_scheduler: directed checks of scan order, timing, scrolling, wrap, pause and reset.
module tb_stair_scheduler;
    localparam int FC = 10;
    localparam int W  = 40;
    localparam int H  = 5;
    localparam int N  = 3;
    localparam int PH = N * W * H;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       go = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic [7:0] frame_count;
    logic [2:0] current_state;

    stair_scheduler #(.FRAME_CYCLES(FC)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .go(go),
        .pause(pause),
        .x(x),
        .y(y),
        .colour(colour),
        .plot(plot),
        .busy(busy),
        .frame_count(frame_count),
        .current_state(current_state)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total = 0;
    int ym [N];
    int n, errs, gap, fexp;
    int fx, fy, lx, ly;
    int sy [N];
    int dfx, dfy, dlx, dly, efx, efy, elx, ely;
    int dsy [N];

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic int exp_colour(input int k, input bit erase);
        if (erase) return 0;
`ifdef STAIR_SCHED_PALETTE_EN
        return 1 + k % 7;
`else
        return 4;
`endif
    endfunction

    // Entered with the first pixel of a phase visible; leaves at the first sample with plot low.
    task automatic run_phase(input bit erase);
        int k, r, c;
        n = 0;
        errs = 0;
        while (plot && n < PH + 50) begin
            k = n / (W * H);
            r = (n % (W * H)) / W;
            c = n % W;
            if (k >= N) errs++;
            else if (int'(x) != (10 + 50 * k + c) % 256 || int'(y) != (ym[k] + r) % 128 ||
                     int'(colour) != exp_colour(k, erase)) errs++;
            if (n == 0) begin
                fx = x;
                fy = y;
            end
            if (k < N && r == 0 && c == 0) sy[k] = y;
            lx = x;
            ly = y;
            n++;
            tick();
        end
    endtask

    task automatic count_gap;
        gap = 0;
        while (!plot && gap < 200) begin
            gap++;
            tick();
        end
    endtask

    task automatic update_model;
        for (int k = 0; k < N; k++) ym[k] = ym[k] == 0 ? 114 : ym[k] - 1;
    endtask

    // Entered with the first draw pixel visible; leaves with the next frame's first draw pixel visible.
    task automatic frame;
        run_phase(1'b0);
        dfx = fx; dfy = fy; dlx = lx; dly = ly;
        for (int k = 0; k < N; k++) dsy[k] = sy[k];
        check("draw_count", n, PH);
        check("draw_pixels", errs, 0);
        count_gap();
        check("wait_gap", gap, FC);
        run_phase(1'b1);
        efx = fx; efy = fy; elx = lx; ely = ly;
        check("erase_count", n, PH);
        check("erase_pixels", errs, 0);
        update_model();
        fexp++;
        check("frame_count", frame_count, fexp);
        check("update_state", current_state, 2);
        count_gap();
        check("update_gap", gap, 1);
    endtask

    initial begin
        for (int k = 0; k < N; k++) ym[k] = 40 + 35 * k;
        fexp = 0;
        tick();
        tick();
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_fc", frame_count, 0);
        check("rst_state", current_state, 0);
        reset_n = 1'b1;
        tick();
        check("idle_hold", current_state, 0);
        go = 1'b1;
        tick();
        check("start_wait", current_state, 1);
        go = 1'b0;
        tick();
        check("draw_entry", current_state, 2);
        check("draw_entry_plot", plot, 0);
        check("draw_entry_busy", busy, 1);
        tick();
        frame();
        check("f1_first_x", dfx, 10);
        check("f1_first_y", dfy, 40);
        check("f1_last_x", dlx, 149);
        check("f1_last_y", dly, 114);
        check("f1_erase_first_x", efx, 10);
        check("f1_erase_first_y", efy, 40);
        check("f1_erase_last_x", elx, 149);
        check("f1_erase_last_y", ely, 114);
        frame();
        check("f2_first_y", dfy, 39);
        check("f2_last_y", dly, 113);
        for (int f = 3; f <= 40; f++) frame();
        frame();
        check("f41_stair0_y", dsy[0], 0);
        frame();
        check("f42_stair0_wrap", dsy[0], 114);
        check("f42_stair1_y", dsy[1], 34);
        run_phase(1'b0);
        check("pre_pause_draw", n, PH);
        pause = 1'b1;
        gap = 0;
        repeat (50) begin
            tick();
            if (plot) gap++;
        end
        check("pause_plot", gap, 0);
        check("pause_fc", frame_count, fexp);
        check("pause_state", current_state, 3);
        pause = 1'b0;
        tick();
        check("unpause_erase", current_state, 4);
        tick();
        check("unpause_plot", plot, 1);
        run_phase(1'b1);
        check("pause_erase_count", n, PH);
        check("pause_erase_pixels", errs, 0);
        update_model();
        fexp++;
        check("pause_fc_after", frame_count, fexp);
        count_gap();
        repeat (100) tick();
        check("mid_draw_plot", plot, 1);
        reset_n = 1'b0;
        #1;
        check("arst_x", x, 0);
        check("arst_y", y, 0);
        check("arst_plot", plot, 0);
        check("arst_busy", busy, 0);
        check("arst_fc", frame_count, 0);
        check("arst_state", current_state, 0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < N; k++) ym[k] = 40 + 35 * k;
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        run_phase(1'b0);
        check("rerun_count", n, PH);
        check("rerun_pixels", errs, 0);
        check("rerun_y0", sy[0], 40);
        check("rerun_y1", sy[1], 75);
        check("rerun_y2", sy[2], 110);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/stair_scheduler.md
# stair_scheduler

Sequencer that shares a single VGA plot port between `NUM_STAIRS` scrolling stair rectangles. It owns each stair's position and scans every pixel itself. Each frame it draws all stairs, waits one frame period, erases all stairs at their old positions, moves every stair up by one row, then redraws. It sits between the top-level game FSM and the VGA adapter, and replaces per-stair draw datapaths and muxing.

## Interface
- `NUM_STAIRS`, default 3: number of stairs, 1..7.
- `STAIR_W`, default 40: rectangle width in pixels.
- `STAIR_H`, default 5: rectangle height in pixels.
- `X_BASE`, default 10: x of stair 0. `X_PITCH`, default 50: x step per stair.
- `Y_BASE`, default 40: reset y of stair 0. `Y_PITCH`, default 35: y step per stair.
- `Y_WRAP`, default 114: y loaded when a stair at y=0 moves up.
- `FRAME_CYCLES`, default 833_334: cycles spent in WAIT per frame; must be ≥1.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `go` in 1: start request. Acted on at release (level high, then low).
- `pause` in 1: while high, frame ticks are ignored and the block holds in WAIT.
- `x` out 8: pixel x (registered).
- `y` out 7: pixel y (registered).
- `colour` out 3: pixel colour (registered).
- `plot` out 1: VGA write enable, one pixel per cycle.
- `busy` out 1: high in DRAW, ERASE and UPDATE.
- `frame_count` out 8: completed frames, wraps 255→0.
- `current_state` out 3: state encoding, for debug LEDs.

## Operation
- States: IDLE=0, START_WAIT=1, DRAW=2, WAIT=3, ERASE=4, UPDATE=5. Codes 6 and 7 go to IDLE.
- Transitions:
  - IDLE → START_WAIT when `go`=1.
  - START_WAIT → DRAW when `go`=0.
  - DRAW → WAIT after its last pixel.
  - WAIT → ERASE when the frame timer is 0 and `pause`=0.
  - ERASE → UPDATE after its last pixel.
  - UPDATE → DRAW (one cycle).
- `go` is ignored outside IDLE and START_WAIT.
- Stair k position:
  - x_k = X_BASE + k·X_PITCH (constant).
  - y_k is a register reset to Y_BASE + k·Y_PITCH.
- Scan in DRAW and ERASE:
  - Counters: cx 0..STAIR_W−1 (fastest), ry 0..STAIR_H−1, s 0..NUM_STAIRS−1.
  - Pixel: x = x_s + cx, y = y_s + ry. Arithmetic is unsigned and truncated to 8 and 7 bits.
  - A phase is NUM_STAIRS·STAIR_W·STAIR_H cycles (600 at defaults), with `plot`=1 on every cycle.
  - Counters clear at the start of each phase.
- `colour`: 3'b000 in ERASE; in DRAW, 3'b100 (see Configuration).
- UPDATE: every y_k is updated in the same cycle. If y_k = 0, y_k ← Y_WRAP; otherwise y_k ← y_k − 1. `frame_count` increments.
- Frame timer: loaded with FRAME_CYCLES−1 on entry to WAIT. It decrements each WAIT cycle and holds at 0.
- `pause` asserted during DRAW or ERASE has no effect until WAIT.
- Reset (at any time, including mid-scan):
  - State IDLE; all y_k at reset values; counters and timer 0.
  - Outputs: `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `frame_count`=0, `current_state`=0.

## Timing
- Outputs are registered. The pixel for scan index i appears on the cycle after the state register enters DRAW or ERASE with that index.
- `plot`=1 for exactly 600 consecutive cycles per phase at defaults. It is 0 in IDLE, START_WAIT, WAIT and UPDATE.
- First `plot` occurs 1 cycle after the DRAW entry edge.
- WAIT lasts FRAME_CYCLES cycles when `pause`=0.
- Frame period = 2·600 + FRAME_CYCLES + 1 (UPDATE) cycles, plus any register-stage slack, which must be constant per frame.
- A `go` pulse of 1 cycle is sufficient.

## Configuration
- `STAIR_SCHED_PALETTE_EN` defined: DRAW colour for stair k = 3'd1 + (k mod 7), giving stair 0 = 3'b001, stair 1 = 3'b010, stair 2 = 3'b011.
- Undefined: all stairs draw 3'b100.
- ERASE is always 3'b000.

## Test plan
- Reset: assert `reset_n`=0 mid-DRAW → all outputs 0 immediately, `current_state`=0; after release, y positions are 40/75/110.
- Start: pulse `go` (FRAME_CYCLES=10) → 600 `plot` cycles. First pixel (10,40), last pixel (149,114), colour 3'b100; then `plot`=0 for exactly 10 cycles.
- Erase and move: continue → 600 erase pixels with colour 0 at the same coordinates, `frame_count`=1. The next DRAW's first pixel is (10,39); stair 2's last pixel is (149,113).
- Wrap: run 40 frames → stair 0 at y=0; the next UPDATE gives y_0=114 while stair 1 moves 35→34.
- Pause: hold `pause`=1 in WAIT for 50 cycles → no `plot` and `frame_count` unchanged. Release → ERASE begins on the next cycle.
- Palette: with `STAIR_SCHED_PALETTE_EN` defined → DRAW colours 3'b001/3'b010/3'b011 per stair; ERASE stays 0.
